muldiv_unit: RTL and testbench

//   Iterative, multi-cycle RV32M execution unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.

---
 rtl/muldiv_unit_pkg.sv | 56 +++++
 rtl/muldiv_unit_if.sv | 24 ++
 rtl/muldiv_unit_datapath.sv | 51 +++++
 rtl/muldiv_unit.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
//   Shared definitions for the iterative RV32M multiply/divide unit:
//   operand width, iteration count, funct3 opcodes, FSM state encoding and
//   an opcode decoder that turns funct3 into datapath/sign-handling flags.
package muldiv_unit_pkg;

  // Only a 32-bit datapath is supported.
  localparam int XLEN       = 32;
  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = $clog2(ITER_COUNT);

  // funct3 encodings
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  // is_div   : restoring-divide datapath instead of shift-add
  // want_alt : high product word (MULH*) or remainder (REM*)
  // signed_a : rs1 is two's complement
  // signed_b : rs2 is two's complement
  typedef struct packed {
    logic is_div;
    logic want_alt;
    logic signed_a;
    logic signed_b;
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic [2:0] sel);
    op_dec_t d;
    d = '0;
    case (sel)
      MD_MUL:    d = '{is_div: 1'b0, want_alt: 1'b0, signed_a: 1'b0, signed_b: 1'b0};
      MD_MULH:   d = '{is_div: 1'b0, want_alt: 1'b1, signed_a: 1'b1, signed_b: 1'b1};
      MD_MULHSU: d = '{is_div: 1'b0, want_alt: 1'b1, signed_a: 1'b1, signed_b: 1'b0};
      MD_MULHU:  d = '{is_div: 1'b0, want_alt: 1'b1, signed_a: 1'b0, signed_b: 1'b0};
      MD_DIV:    d = '{is_div: 1'b1, want_alt: 1'b0, signed_a: 1'b1, signed_b: 1'b1};
      MD_DIVU:   d = '{is_div: 1'b1, want_alt: 1'b0, signed_a: 1'b0, signed_b: 1'b0};
      MD_REM:    d = '{is_div: 1'b1, want_alt: 1'b1, signed_a: 1'b1, signed_b: 1'b1};
      default:   d = '{is_div: 1'b1, want_alt: 1'b1, signed_a: 1'b0, signed_b: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if
//   Request/response bundle between the EX stage and the multiply/divide unit.
//   master : EX stage  (drives START/FLUSH/SELECT/DATA1/DATA2)
//   slave  : muldiv_unit (drives BUSY/DONE/RESULT)
interface muldiv_unit_if;
  logic        START;
  logic        FLUSH;
  logic [2:0]  SELECT;
  logic [31:0] DATA1;
  logic [31:0] DATA2;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  modport master (
    output START, FLUSH, SELECT, DATA1, DATA2,
    input  BUSY, DONE, RESULT
  );

  modport slave (
    input  START, FLUSH, SELECT, DATA1, DATA2,
    output BUSY, DONE, RESULT
  );
endinterface

// File: rtl/muldiv_unit_datapath.sv
// muldiv_unit_datapath
//   One combinational radix-2 step over unsigned magnitudes, sharing the same
//   {hi, lo} register pair for both operations.
//   Ports:
//     is_div : 1 = restoring-divide step, 0 = shift-add multiply step
//     hi_i   : multiply: upper partial product   / divide: partial remainder
//     lo_i   : multiply: lower product+multiplier / divide: dividend bits -> quotient
//     b_i    : multiplicand or divisor magnitude
//     hi_o   : next hi value
//     lo_o   : next lo value
module muldiv_unit_datapath
  import muldiv_unit_pkg::*;
(
  input  logic            is_div,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   partial;
  logic [XLEN-1:0] trial;
  logic            fits;

  always_comb begin
    hi_o    = hi_i;
    lo_o    = lo_i;
    add_sum = '0;
    partial = '0;
    trial   = '0;
    fits    = 1'b0;
    if (!is_div) begin
      // Add multiplicand when the current multiplier LSB is set, then shift the
      // whole 65-bit {carry, hi, lo} right by one; multiplier bits drain out of lo.
      add_sum      = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
      {hi_o, lo_o} = {add_sum, lo_i[XLEN-1:1]};
    end else begin
      // Bring the next dividend bit into the remainder; the partial value can be
      // 33 bits wide, so the compare uses the full width while the subtraction
      // only needs the low word (the result is always below the divisor).
      partial = {hi_i, lo_i[XLEN-1]};
      fits    = (partial >= {1'b0, b_i});
      trial   = partial[XLEN-1:0] - b_i;
      hi_o    = fits ? trial : partial[XLEN-1:0];
      lo_o    = {lo_i[XLEN-2:0], fits};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative RV32M execution unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//   A request is accepted in IDLE, runs 32 radix-2 steps over operand
//   magnitudes, applies sign correction in FIX and pulses DONE in FIN.
//   Divide-by-zero and signed overflow are resolved at acceptance and go
//   straight to FIN.
//   Ports:
//     CLK    : rising-edge clock
//     RESETN : asynchronous active-low reset
//     bus    : slave side of muldiv_unit_if (START/FLUSH/SELECT/DATA1/DATA2 in,
//              BUSY/DONE/RESULT out)
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic          CLK,
  input  logic          RESETN,
  muldiv_unit_if.slave  bus
);

  state_e          state_q,   state_d;
  logic [CNT_W-1:0] count_q,  count_d;
  op_dec_t         op_q,      op_d;
  logic            neg_res_q, neg_res_d;   // product / quotient sign
  logic            neg_rem_q, neg_rem_d;   // remainder sign (dividend sign)
  logic [XLEN-1:0] b_q,       b_d;
  logic [XLEN-1:0] hi_q,      hi_d;
  logic [XLEN-1:0] lo_q,      lo_d;
  logic            busy_q,    busy_d;
  logic            done_q,    done_d;
  logic [XLEN-1:0] result_q,  result_d;

  // Acceptance-time decode
  op_dec_t         op_in;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_result;

  // Datapath step
  logic [XLEN-1:0] step_hi, step_lo;

  // Sign fix-up
  logic [2*XLEN-1:0] prod_raw, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

  muldiv_unit_datapath u_datapath (
    .is_div (op_q.is_div),
    .hi_i   (hi_q),
    .lo_i   (lo_q),
    .b_i    (b_q),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

  always_comb begin
    op_in = decode_op(bus.SELECT);
    neg_a = op_in.signed_a & bus.DATA1[XLEN-1];
    neg_b = op_in.signed_b & bus.DATA2[XLEN-1];
    // As unsigned values, |0x80000000| = 0x80000000 still fits in 32 bits, so
    // the most-negative operand needs no extra magnitude bit here.
    mag_a = neg_a ? (~bus.DATA1 + 32'd1) : bus.DATA1;
    mag_b = neg_b ? (~bus.DATA2 + 32'd1) : bus.DATA2;

    div_zero = op_in.is_div && (bus.DATA2 == '0);
    div_ovf  = op_in.is_div && op_in.signed_a &&
               (bus.DATA1 == 32'h8000_0000) && (bus.DATA2 == 32'hFFFF_FFFF);
    if (div_zero) begin
      special_result = op_in.want_alt ? bus.DATA1 : 32'hFFFF_FFFF;
    end else begin
      special_result = op_in.want_alt ? 32'h0000_0000 : 32'h8000_0000;
    end
  end

  always_comb begin
    prod_raw   = {hi_q, lo_q};
    prod_fix   = neg_res_q ? (~prod_raw + 64'd1) : prod_raw;
    quo_fix    = neg_res_q ? (~lo_q + 32'd1) : lo_q;
    rem_fix    = neg_rem_q ? (~hi_q + 32'd1) : hi_q;
    if (op_q.is_div) begin
      fix_result = op_q.want_alt ? rem_fix : quo_fix;
    end else begin
      fix_result = op_q.want_alt ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.START && !bus.FLUSH) begin
          op_d      = op_in;
          neg_res_d = neg_a ^ neg_b;
          neg_rem_d = neg_a;
          count_d   = '0;
          // Same initial layout serves both paths: lo holds the multiplier or
          // the dividend, hi starts as the empty partial product/remainder.
          hi_d      = '0;
          lo_d      = mag_a;
          b_d       = mag_b;
          if (div_zero || div_ovf) begin
            result_d = special_result;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = ST_FIN;
          end else begin
            busy_d   = 1'b1;
            state_d  = ST_ITER;
          end
        end
      end
      ST_ITER: begin
        hi_d    = step_hi;
        lo_d    = step_lo;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(ITER_COUNT - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        result_d = fix_result;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_FIN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides everything: no DONE, RESULT keeps its previous value.
    // In FIN the pulse is already on the output, so only the return to IDLE matters.
    if (bus.FLUSH) begin
      state_d  = ST_IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;
  assign bus.RESULT = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
//   Directed and random stimulus for muldiv_unit. Expected results come from a
//   behavioural reference model and travel through a scoreboard queue from
//   issue to DONE.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if bus();

  muldiv_unit dut (
    .CLK    (clk),
    .RESETN (rst_n),
    .bus    (bus)
  );

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result = 32'h0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] sel, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0]        ua, ub, up;
    logic signed [31:0] s1, s2;
    logic [31:0]        r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    s1 = a;
    s2 = b;
    r  = 32'h0;
    case (sel)
      3'd0: begin up = ua * ub; r = up[31:0]; end
      3'd1: begin sp = sa * sb; r = sp[63:32]; end
      3'd2: begin sp = sa * $signed(ub); r = sp[63:32]; end
      3'd3: begin up = ua * ub; r = up[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = s1 / s2;
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else r = s1 % s2;
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Issue one op and follow it to DONE. Cycle n counts negedges after the
  // accepting edge; inj != 0 pulses a second START while the unit is busy.
  task automatic run_op(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input int inj);
    int          n, busy_n;
    bit          seen, special;
    logic [31:0] got_exp;
    special = sel[2] && ((b == 0) || (!sel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    @(negedge clk);
    bus.START  = 1'b1;
    bus.SELECT = sel;
    bus.DATA1  = a;
    bus.DATA2  = b;
    exp_q.push_back(ref_model(sel, a, b));
    @(negedge clk);
    bus.START = 1'b0;
    bus.DATA1 = $urandom;
    bus.DATA2 = $urandom;
    n = 1; busy_n = 0; seen = 0;
    while (n <= 100) begin
      if (bus.DONE) begin seen = 1; break; end
      if (bus.BUSY) busy_n++;
      bus.START = (inj != 0 && n == inj);
      @(negedge clk);
      n++;
    end
    bus.START = 1'b0;
    if (!seen) begin
      check("done_timeout", 64'd0, 64'd1);
      void'(exp_q.pop_front());
      return;
    end
    check($sformatf("latency_sel%0d", sel), 64'(n), special ? 64'd1 : 64'd34);
    check($sformatf("busy_cycles_sel%0d", sel), 64'(busy_n), special ? 64'd0 : 64'd33);
    check("busy_low_at_done", 64'(bus.BUSY), 64'd0);
    got_exp = exp_q.pop_front();
    check($sformatf("result_sel%0d_%h_%h", sel, a, b), 64'(bus.RESULT), 64'(got_exp));
    last_result = got_exp;
    $display("op sel=%0d a=%h b=%h result=%h latency=%0d", sel, a, b, bus.RESULT, n);
    @(negedge clk);
    check("done_one_cycle", 64'(bus.DONE), 64'd0);
    check("result_held", 64'(bus.RESULT), 64'(got_exp));
  endtask

  task automatic no_done(input int cycles);
    int d;
    d = 0;
    repeat (cycles) begin
      if (bus.DONE) d++;
      @(negedge clk);
    end
    check("no_done", 64'(d), 64'd0);
    check("result_kept", 64'(bus.RESULT), 64'(last_result));
  endtask

  initial begin
    logic [2:0]  sel;
    logic [31:0] a, b;
    bus.START  = 1'b0;
    bus.FLUSH  = 1'b0;
    bus.SELECT = 3'd0;
    bus.DATA1  = 32'h0;
    bus.DATA2  = 32'h0;
    rst_n      = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_busy",   64'(bus.BUSY),   64'd0);
    check("reset_done",   64'(bus.DONE),   64'd0);
    check("reset_result", 64'(bus.RESULT), 64'd0);
    rst_n = 1'b1;

    // Basic multiply with timing
    run_op(MD_MUL, 32'd7, 32'hFFFF_FFFD, 0);
    check("mul_7_m3", 64'(last_result), 64'hFFFF_FFEB);

    // High-word multiplies
    run_op(MD_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(MD_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(MD_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(MD_MULH,   32'h8000_0000, 32'h8000_0000, 0);

    // Divide / remainder
    run_op(MD_DIV,  32'hFFFF_FFEC, 32'd3, 0);
    run_op(MD_REM,  32'hFFFF_FFEC, 32'd3, 0);
    run_op(MD_DIVU, 32'd20, 32'd3, 0);
    run_op(MD_REMU, 32'd20, 32'd3, 0);

    // Special cases resolved at acceptance
    run_op(MD_DIV,  32'd55, 32'd0, 0);
    run_op(MD_REMU, 32'h0000_1234, 32'd0, 0);
    run_op(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0);

    // FLUSH during ITER
    @(negedge clk);
    bus.START = 1'b1; bus.SELECT = MD_DIVU; bus.DATA1 = 32'd1000; bus.DATA2 = 32'd7;
    @(negedge clk);
    bus.START = 1'b0;
    repeat (9) @(negedge clk);      // now in cycle 10
    check("busy_before_flush", 64'(bus.BUSY), 64'd1);
    bus.FLUSH = 1'b1;
    @(negedge clk);                 // cycle 11
    bus.FLUSH = 1'b0;
    check("busy_after_flush", 64'(bus.BUSY), 64'd0);
    no_done(40);
    $display("flush during ITER");

    // START and FLUSH together: not accepted
    @(negedge clk);
    bus.START = 1'b1; bus.FLUSH = 1'b1; bus.SELECT = MD_DIV; bus.DATA1 = 32'd99; bus.DATA2 = 32'd4;
    @(negedge clk);
    bus.START = 1'b0; bus.FLUSH = 1'b0;
    check("start_flush_busy", 64'(bus.BUSY), 64'd0);
    no_done(40);
    $display("start with flush dropped");

    // START while BUSY is ignored
    run_op(MD_MUL, 32'd1234, 32'd5678, 5);
    no_done(40);

    // Reset in the middle of a multiply
    @(negedge clk);
    bus.START = 1'b1; bus.SELECT = MD_MUL; bus.DATA1 = 32'd11; bus.DATA2 = 32'd13;
    @(negedge clk);
    bus.START = 1'b0;
    repeat (14) @(negedge clk);     // cycle 15
    rst_n = 1'b0;
    #1;
    check("rst_busy",   64'(bus.BUSY),   64'd0);
    check("rst_done",   64'(bus.DONE),   64'd0);
    check("rst_result", 64'(bus.RESULT), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_result = 32'h0;
    no_done(40);
    $display("reset mid-operation");

    // Random regression
    for (int i = 0; i < 1000; i++) begin
      sel = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 255)); b = 32'($urandom_range(1, 15)); end
        3: b = 32'($urandom_range(1, 3)) ^ {32{b[31]}};
        default: ;
      endcase
      run_op(sel, a, b, 0);
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
